pcie_rq_arbiter: RTL and testbench

Packet-atomic N-to-1 arbiter that merges several user requester streams onto the single `s_axis_rq_*` AXI-stream port of the PCIe endpoint. It generalises the fixed 64-bit, single-source requester path to a parametrised data width and channel count, and adds round-robin arbitration and a registered 2-entry output buffer. It sits between the user DMA/request engines and the PCIe core's RQ interface, in the `user_clk_out` domain.

---
 rtl/pcie_arb_pkg.sv | 14 +
 rtl/pcie_axis_skid.sv | 59 +++++
 rtl/pcie_rq_arbiter.sv | 138 +++++++++++++
 tb/tb_pcie_rq_arbiter.sv | 335 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pcie_arb_pkg.sv
// Shared types and helpers for the PCIe RQ arbiter.
// The beat struct is declared in the top module because its widths follow the module parameters.
package pcie_arb_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    PKT  = 1'b1
  } arb_state_t;

  function automatic int ch_width(input int num_ch);
    return (num_ch > 1) ? $clog2(num_ch) : 1;
  endfunction

endpackage

// File: rtl/pcie_axis_skid.sv
// Two-entry registered FIFO carrying whole AXI-stream beats.
// Output is driven straight from the head register, so it holds steady under backpressure.
module pcie_axis_skid #(
  parameter type beat_t = logic
) (
  input  logic  clk,
  input  logic  rst_n,
  input  logic  in_valid,
  output logic  in_ready,
  input  beat_t in_beat,
  output logic  out_valid,
  input  logic  out_ready,
  output beat_t out_beat
);

  logic [1:0] count;
  beat_t      head;
  beat_t      tail;
  logic       push;
  logic       pop;

  assign in_ready  = (count < 2'd2);
  assign out_valid = (count != 2'd0);
  assign out_beat  = head;
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= 2'd0;
      // NOTE: the entries are reset because the head drives the outputs, which must read 0 out of reset.
      head  <= '0;
      tail  <= '0;
    end else begin
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase

      // A full buffer never pushes, so a pop there only shifts tail into head.
      if (pop) begin
        if (count == 2'd2) begin
          head <= tail;
        end else if (push) begin
          head <= in_beat;
        end
      end else if (push) begin
        if (count == 2'd0) begin
          head <= in_beat;
        end else begin
          tail <= in_beat;
        end
      end
    end
  end

endmodule

// File: rtl/pcie_rq_arbiter.sv
// Packet-atomic round-robin N-to-1 arbiter feeding the PCIe core RQ AXI-stream port.
// Optional macro PCIE_RQ_ARB_PRIO_EN gives channel 0 strict priority at arbitration time.
module pcie_rq_arbiter
  import pcie_arb_pkg::*;
#(
  parameter  int PCIE_DATA_WIDTH = 64,
  parameter  int PCIE_KEEP_WIDTH = PCIE_DATA_WIDTH / 32,
  parameter  int PCIE_USER_WIDTH = 85,
  parameter  int NUM_CH          = 4,
  localparam int CH_W            = ch_width(NUM_CH)
) (
  input  logic                                 pcie_clk_in,
  input  logic                                 pcie_reset_n_in,
  input  logic [NUM_CH*PCIE_DATA_WIDTH-1:0]    in_tdata,
  input  logic [NUM_CH*PCIE_USER_WIDTH-1:0]    in_tuser,
  input  logic [NUM_CH*PCIE_KEEP_WIDTH-1:0]    in_tkeep,
  input  logic [NUM_CH-1:0]                    in_tlast,
  input  logic [NUM_CH-1:0]                    in_tvalid,
  output logic [NUM_CH-1:0]                    in_tready,
  output logic [PCIE_DATA_WIDTH-1:0]           s_axis_rq_tdata,
  output logic [PCIE_USER_WIDTH-1:0]           s_axis_rq_tuser,
  output logic [PCIE_KEEP_WIDTH-1:0]           s_axis_rq_tkeep,
  output logic                                 s_axis_rq_tlast,
  output logic                                 s_axis_rq_tvalid,
  input  logic                                 s_axis_rq_tready,
  output logic [CH_W-1:0]                      grant_ch,
  output logic                                 busy
);

  typedef struct packed {
    logic [PCIE_DATA_WIDTH-1:0] data;
    logic [PCIE_USER_WIDTH-1:0] user;
    logic [PCIE_KEEP_WIDTH-1:0] keep;
    logic                       last;
  } beat_t;

  arb_state_t      state;
  arb_state_t      state_nxt;
  logic [CH_W-1:0] last_grant;
  logic [CH_W-1:0] winner;
  logic [CH_W-1:0] cand;
  logic [NUM_CH-1:0] rr_req;
  logic            prio_hit;
  logic            rr_update;
  logic            found;
  logic            any_valid;
  logic            buf_ready;
  logic            push;
  beat_t           in_beat;
  beat_t           out_beat;

`ifdef PCIE_RQ_ARB_PRIO_EN
  // Channel 0 sits outside the rotation so it never disturbs fairness among the others.
  assign rr_req    = {in_tvalid[NUM_CH-1:1], 1'b0};
  assign prio_hit  = in_tvalid[0];
  assign rr_update = (grant_ch != '0);
`else
  assign rr_req    = in_tvalid;
  assign prio_hit  = 1'b0;
  assign rr_update = 1'b1;
`endif

  assign any_valid = |in_tvalid;

  // NOTE: every combinational output gets a default first so no path can infer a latch.
  always_comb begin
    winner = '0;
    cand   = '0;
    found  = prio_hit;
    for (int i = 1; i <= NUM_CH; i++) begin
      cand = CH_W'((int'(last_grant) + i) % NUM_CH);
      if (!found && rr_req[cand]) begin
        winner = cand;
        found  = 1'b1;
      end
    end
  end

  assign in_beat.data = in_tdata[grant_ch*PCIE_DATA_WIDTH +: PCIE_DATA_WIDTH];
  assign in_beat.user = in_tuser[grant_ch*PCIE_USER_WIDTH +: PCIE_USER_WIDTH];
  assign in_beat.keep = in_tkeep[grant_ch*PCIE_KEEP_WIDTH +: PCIE_KEEP_WIDTH];
  assign in_beat.last = in_tlast[grant_ch];
  assign push         = in_tvalid[grant_ch] & in_tready[grant_ch];

  always_ff @(posedge pcie_clk_in or negedge pcie_reset_n_in) begin
    if (!pcie_reset_n_in) begin
      state      <= IDLE;
      grant_ch   <= '0;
      last_grant <= CH_W'(NUM_CH - 1);
    end else begin
      state <= state_nxt;
      if (state == IDLE && any_valid) begin
        grant_ch <= winner;
      end
      if (push && in_beat.last && rr_update) begin
        last_grant <= grant_ch;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (any_valid) state_nxt = PKT;
      PKT:     if (push && in_beat.last) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // in_tready is built from registers only, keeping core backpressure off the upstream path.
  always_comb begin
    in_tready = '0;
    busy      = 1'b0;
    if (state == PKT) begin
      in_tready[grant_ch] = buf_ready;
      busy                = 1'b1;
    end
  end

  pcie_axis_skid #(
    .beat_t (beat_t)
  ) u_skid (
    .clk       (pcie_clk_in),
    .rst_n     (pcie_reset_n_in),
    .in_valid  (push),
    .in_ready  (buf_ready),
    .in_beat   (in_beat),
    .out_valid (s_axis_rq_tvalid),
    .out_ready (s_axis_rq_tready),
    .out_beat  (out_beat)
  );

  assign s_axis_rq_tdata = out_beat.data;
  assign s_axis_rq_tuser = out_beat.user;
  assign s_axis_rq_tkeep = out_beat.keep;
  assign s_axis_rq_tlast = out_beat.last;

endmodule

// File: tb/tb_pcie_rq_arbiter.sv
// Self-checking bench for pcie_rq_arbiter: per-channel packet queues feed the DUT and a
// round-robin-ordered expected beat queue scores the merged output stream.
module tb_pcie_rq_arbiter;

  localparam int DW  = 256;
  localparam int KW  = DW / 32;
  localparam int UW  = 85;
  localparam int NC  = 4;
  localparam int CHW = 2;

  typedef struct {
    logic [DW-1:0] data;
    logic [UW-1:0] user;
    logic [KW-1:0] keep;
    logic          last;
  } tb_beat_t;

  logic              clk;
  logic              pcie_reset_n_in;
  logic [NC*DW-1:0]  in_tdata;
  logic [NC*UW-1:0]  in_tuser;
  logic [NC*KW-1:0]  in_tkeep;
  logic [NC-1:0]     in_tlast;
  logic [NC-1:0]     in_tvalid;
  logic [NC-1:0]     in_tready;
  logic [DW-1:0]     s_axis_rq_tdata;
  logic [UW-1:0]     s_axis_rq_tuser;
  logic [KW-1:0]     s_axis_rq_tkeep;
  logic              s_axis_rq_tlast;
  logic              s_axis_rq_tvalid;
  logic              s_axis_rq_tready;
  logic [CHW-1:0]    grant_ch;
  logic              busy;

  pcie_rq_arbiter #(
    .PCIE_DATA_WIDTH (DW),
    .PCIE_KEEP_WIDTH (KW),
    .PCIE_USER_WIDTH (UW),
    .NUM_CH          (NC)
  ) dut (
    .pcie_clk_in      (clk),
    .pcie_reset_n_in  (pcie_reset_n_in),
    .in_tdata         (in_tdata),
    .in_tuser         (in_tuser),
    .in_tkeep         (in_tkeep),
    .in_tlast         (in_tlast),
    .in_tvalid        (in_tvalid),
    .in_tready        (in_tready),
    .s_axis_rq_tdata  (s_axis_rq_tdata),
    .s_axis_rq_tuser  (s_axis_rq_tuser),
    .s_axis_rq_tkeep  (s_axis_rq_tkeep),
    .s_axis_rq_tlast  (s_axis_rq_tlast),
    .s_axis_rq_tvalid (s_axis_rq_tvalid),
    .s_axis_rq_tready (s_axis_rq_tready),
    .grant_ch         (grant_ch),
    .busy             (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Model state: what each channel still has to send, and the order the output must show.
  tb_beat_t      ch_q [NC][$];
  tb_beat_t      exp_q[$];
  tb_beat_t      last_out;
  logic [NC-1:0] ch_en;
  logic [NC-1:0] acc_prev;
  bit            mid [NC];
  int            gap_force [NC];
  int            acc_cnt [NC];
  bit            gaps_on;
  int            bp_mode;
  int            cycle;
  int            first_fire;
  int            last_fire;
  int            n_cmp;
  int            n_err;

  task automatic add_pkt(input int c, input int len, input bit use_keep, input logic [KW-1:0] keep_val);
    for (int i = 0; i < len; i++) begin
      tb_beat_t b;
      for (int k = 0; k < DW / 32; k++) b.data[k*32 +: 32] = $urandom;
      b.user = UW'({$urandom, $urandom, $urandom});
      b.keep = use_keep ? keep_val : KW'($urandom);
      b.last = (i == len - 1);
      ch_q[c].push_back(b);
      exp_q.push_back(b);
    end
  endtask

  // One clock: retire last cycle's accepts, drive inputs on the falling edge, then sample.
  task automatic step();
    @(negedge clk);
    cycle++;
    for (int c = 0; c < NC; c++) begin
      if (acc_prev[c] && ch_q[c].size() > 0) begin
        mid[c] = !ch_q[c][0].last;
        void'(ch_q[c].pop_front());
        acc_cnt[c]++;
      end
    end
    for (int c = 0; c < NC; c++) begin
      bit v;
      v = ch_en[c] && (ch_q[c].size() > 0);
      if (v && mid[c] && gap_force[c] > 0) begin
        v = 1'b0;
        gap_force[c]--;
      end else if (v && mid[c] && gaps_on && $urandom_range(3) == 0) begin
        v = 1'b0;
      end
      in_tvalid[c] = v;
      if (ch_q[c].size() > 0) begin
        in_tdata[c*DW +: DW] = ch_q[c][0].data;
        in_tuser[c*UW +: UW] = ch_q[c][0].user;
        in_tkeep[c*KW +: KW] = ch_q[c][0].keep;
        in_tlast[c]          = ch_q[c][0].last;
      end else begin
        in_tdata[c*DW +: DW] = '0;
        in_tuser[c*UW +: UW] = '0;
        in_tkeep[c*KW +: KW] = '0;
        in_tlast[c]          = 1'b0;
      end
    end
    s_axis_rq_tready = (bp_mode == 0) ? 1'b1 : (bp_mode == 2) ? 1'b0 : 1'($urandom_range(1));
    #1;
    acc_prev = in_tvalid & in_tready;
    n_cmp++;
    if ($countones(in_tready) > 1) begin
      n_err++;
      $display("FAIL tready_onehot cycle %0d: got %b, want at most one bit", cycle, in_tready);
    end
    if (s_axis_rq_tvalid && s_axis_rq_tready) begin
      if (first_fire < 0) first_fire = cycle;
      last_fire = cycle;
      last_out.data = s_axis_rq_tdata;
      last_out.user = s_axis_rq_tuser;
      last_out.keep = s_axis_rq_tkeep;
      last_out.last = s_axis_rq_tlast;
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL out_beat cycle %0d: got unexpected beat data=%h, want none", cycle, s_axis_rq_tdata);
      end else begin
        tb_beat_t e;
        e = exp_q.pop_front();
        if (s_axis_rq_tdata !== e.data || s_axis_rq_tuser !== e.user ||
            s_axis_rq_tkeep !== e.keep || s_axis_rq_tlast !== e.last) begin
          n_err++;
          $display("FAIL out_beat cycle %0d: got data=%h keep=%h last=%b, want data=%h keep=%h last=%b",
                   cycle, s_axis_rq_tdata, s_axis_rq_tkeep, s_axis_rq_tlast, e.data, e.keep, e.last);
        end
      end
    end
  endtask

  task automatic drain(input string name);
    int guard;
    guard = 0;
    while (exp_q.size() != 0 && guard < 3000) begin
      step();
      guard++;
    end
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL %s_drain: got %0d beats outstanding after %0d cycles, want 0", name, exp_q.size(), guard);
    end
    for (int c = 0; c < NC; c++) begin
      ch_q[c].delete();
      mid[c]       = 1'b0;
      gap_force[c] = 0;
    end
    exp_q.delete();
  endtask

  task automatic test_reset();
    pcie_reset_n_in  = 1'b0;
    s_axis_rq_tready = 1'b1;
    in_tvalid        = '1;
    in_tlast         = '0;
    in_tkeep         = '1;
    for (int c = 0; c < NC; c++) begin
      in_tdata[c*DW +: DW] = {8{32'hC0DE_0000 + 32'(c)}};
      in_tuser[c*UW +: UW] = UW'(c + 1);
    end
    repeat (3) @(negedge clk);
    #1;
    n_cmp++; if (in_tready !== '0)        begin n_err++; $display("FAIL rst_tready: got %b want 0", in_tready); end
    n_cmp++; if (s_axis_rq_tvalid !== 1'b0) begin n_err++; $display("FAIL rst_tvalid: got %b want 0", s_axis_rq_tvalid); end
    n_cmp++; if (s_axis_rq_tlast !== 1'b0) begin n_err++; $display("FAIL rst_tlast: got %b want 0", s_axis_rq_tlast); end
    n_cmp++; if (s_axis_rq_tdata !== '0)  begin n_err++; $display("FAIL rst_tdata: got %h want 0", s_axis_rq_tdata); end
    n_cmp++; if (s_axis_rq_tuser !== '0)  begin n_err++; $display("FAIL rst_tuser: got %h want 0", s_axis_rq_tuser); end
    n_cmp++; if (s_axis_rq_tkeep !== '0)  begin n_err++; $display("FAIL rst_tkeep: got %h want 0", s_axis_rq_tkeep); end
    n_cmp++; if (grant_ch !== '0)         begin n_err++; $display("FAIL rst_grant: got %0d want 0", grant_ch); end
    n_cmp++; if (busy !== 1'b0)           begin n_err++; $display("FAIL rst_busy: got %b want 0", busy); end
    pcie_reset_n_in = 1'b1;
    @(negedge clk); #1;
    n_cmp++; if (grant_ch !== 2'd0)       begin n_err++; $display("FAIL arb_grant: got %0d want 0", grant_ch); end
    n_cmp++; if (busy !== 1'b1)           begin n_err++; $display("FAIL arb_busy: got %b want 1", busy); end
    n_cmp++; if (in_tready !== 4'b0001)   begin n_err++; $display("FAIL arb_tready: got %b want 0001", in_tready); end
    n_cmp++; if (s_axis_rq_tvalid !== 1'b0) begin n_err++; $display("FAIL arb_tvalid: got %b want 0", s_axis_rq_tvalid); end
    @(negedge clk); #1;
    n_cmp++; if (s_axis_rq_tvalid !== 1'b1) begin n_err++; $display("FAIL first_tvalid: got %b want 1", s_axis_rq_tvalid); end
    n_cmp++; if (s_axis_rq_tdata !== {8{32'hC0DE_0000}}) begin n_err++; $display("FAIL first_tdata: got %h want ch0 pattern", s_axis_rq_tdata); end
    pcie_reset_n_in = 1'b0;
    #1;
    n_cmp++; if (s_axis_rq_tvalid !== 1'b0) begin n_err++; $display("FAIL midrst_tvalid: got %b want 0", s_axis_rq_tvalid); end
    n_cmp++; if (busy !== 1'b0)           begin n_err++; $display("FAIL midrst_busy: got %b want 0", busy); end
    n_cmp++; if (in_tready !== '0)        begin n_err++; $display("FAIL midrst_tready: got %b want 0", in_tready); end
    in_tvalid = '0;
    @(negedge clk);
    pcie_reset_n_in = 1'b1;
  endtask

  // Every channel always has a packet waiting, so packets must come out strictly 0,1,2,3,0,...
  task automatic test_round_robin();
    int span;
    ch_en = '1; gaps_on = 1'b0; bp_mode = 0;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < NC; c++) add_pkt(c, 3, 1'b0, '0);
    first_fire = -1;
    drain("round_robin");
    span = last_fire - first_fire + 1;
    n_cmp++;
    if (span !== 4 * 12 - 1) begin
      n_err++;
      $display("FAIL rr_throughput: got %0d cycles for 12 packets, want %0d", span, 4 * 12 - 1);
    end
  endtask

  task automatic test_random_stream();
    ch_en = '1; gaps_on = 1'b1; bp_mode = 1;
    for (int r = 0; r < 5; r++)
      for (int c = 0; c < NC; c++) add_pkt(c, $urandom_range(1, 4), 1'b0, '0);
    drain("random_stream");
    gaps_on = 1'b0; bp_mode = 0;
  endtask

  task automatic test_backpressure();
    int       base;
    tb_beat_t head;
    ch_en = 4'b0100; gaps_on = 1'b0; bp_mode = 2;
    add_pkt(2, 6, 1'b0, '0);
    head = exp_q[0];
    base = acc_cnt[2];
    repeat (12) step();
    n_cmp++; if (acc_cnt[2] - base !== 2) begin n_err++; $display("FAIL bp_buffered: got %0d beats accepted, want 2", acc_cnt[2] - base); end
    n_cmp++; if (in_tready !== '0)        begin n_err++; $display("FAIL bp_tready: got %b want 0", in_tready); end
    n_cmp++; if (s_axis_rq_tvalid !== 1'b1) begin n_err++; $display("FAIL bp_tvalid: got %b want 1", s_axis_rq_tvalid); end
    n_cmp++; if (s_axis_rq_tdata !== head.data) begin n_err++; $display("FAIL bp_hold: got %h want %h", s_axis_rq_tdata, head.data); end
    bp_mode = 0;
    drain("backpressure");
  endtask

  task automatic test_atomicity();
    int base;
    int guard;
    ch_en = 4'b0010; gaps_on = 1'b0; bp_mode = 0;
    add_pkt(1, 4, 1'b0, '0);
    add_pkt(2, 3, 1'b0, '0);
    base  = acc_cnt[1];
    guard = 0;
    while (acc_cnt[1] == base && guard < 20) begin
      step();
      guard++;
    end
    n_cmp++;
    if (acc_cnt[1] == base) begin
      n_err++;
      $display("FAIL atomic_start: got no ch1 beat in %0d cycles, want one", guard);
    end
    ch_en        = 4'b0110;
    gap_force[1] = 5;
    for (int i = 0; i < 5; i++) begin
      step();
      n_cmp++;
      if (grant_ch !== 2'd1 || busy !== 1'b1) begin
        n_err++;
        $display("FAIL atomic_hold gap %0d: got grant=%0d busy=%b, want grant=1 busy=1", i, grant_ch, busy);
      end
    end
    drain("atomicity");
  endtask

  task automatic test_width();
    tb_beat_t want;
    ch_en = 4'b1000; gaps_on = 1'b0; bp_mode = 0;
    add_pkt(3, 1, 1'b1, 8'h0F);
    want = exp_q[0];
    drain("width");
    n_cmp++; if (last_out.keep !== 8'h0F) begin n_err++; $display("FAIL width_keep: got %h want 0f", last_out.keep); end
    n_cmp++; if (last_out.last !== 1'b1)  begin n_err++; $display("FAIL width_last: got %b want 1", last_out.last); end
    n_cmp++; if (last_out.data !== want.data) begin n_err++; $display("FAIL width_data: got %h want %h", last_out.data, want.data); end
  endtask

  // Channel 0 and 3 both keep requesting; the previous packet went to ch3, so ch0 goes first.
  task automatic test_ch0_ch3();
    ch_en = 4'b1001; gaps_on = 1'b0; bp_mode = 0;
`ifdef PCIE_RQ_ARB_PRIO_EN
    for (int p = 0; p < 4; p++) add_pkt(0, 2, 1'b0, '0);
    for (int p = 0; p < 4; p++) add_pkt(3, 2, 1'b0, '0);
`else
    for (int p = 0; p < 4; p++) begin
      add_pkt(0, 2, 1'b0, '0);
      add_pkt(3, 2, 1'b0, '0);
    end
`endif
    drain("ch0_ch3");
  endtask

  initial begin
    n_cmp = 0; n_err = 0; cycle = 0;
    first_fire = -1; last_fire = -1;
    acc_prev = '0; ch_en = '0; gaps_on = 1'b0; bp_mode = 0;
    in_tdata = '0; in_tuser = '0; in_tkeep = '0; in_tlast = '0; in_tvalid = '0;
    s_axis_rq_tready = 1'b1;
    pcie_reset_n_in  = 1'b0;
    last_out = '{default: '0};
    for (int c = 0; c < NC; c++) begin
      mid[c] = 1'b0; gap_force[c] = 0; acc_cnt[c] = 0;
    end
    test_reset();
    test_round_robin();
    test_random_stream();
    test_backpressure();
    test_atomicity();
    test_width();
    test_ch0_ch3();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
